// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter family and its requester-side agent.
// Also used by arbiter benches, hence the wide fixed-width one-hot check.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int ONEHOT_MAX_W = 64;

    // Index width for a vector of 'value' entries, never below one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic logic onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/request_pending_counter.sv
// Per-channel pending-item counter: saturating increment, decrement, and a
// simultaneous inc/dec that leaves the count unchanged even at the maximum.
module request_pending_counter #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic is_one,
    output logic full
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign nonzero = |cnt_q;
    assign is_one  = (cnt_q == CNT_W'(1));
    assign full    = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && nonzero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/arbiter_request_agent.sv
// Requester side of the request/grant handshake: queues per-channel work,
// requests from registered state only, and serves each grant as a capped burst.
module arbiter_request_agent import arb_pkg::*; #(
    parameter int width     = 8,
    parameter int CNT_W     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [width-1:0]             push,
    output logic [width-1:0]             request,
    input  logic [width-1:0]             grant,
    output logic                         beat_valid,
    output logic [clog2(width)-1:0]      beat_ch,
    output logic                         beat_last,
    output logic [width-1:0]             pending_full,
    output logic                         busy,
    output logic                         grant_error,
    input  logic                         err_clr
);

    localparam int CH_W = clog2(width);
    localparam int BC_W = clog2(BURST_LEN);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [BC_W-1:0]   beat_q, beat_d;
    logic              err_q, err_d;

    logic [width-1:0]  dec, nonzero, is_one;
    logic [CH_W-1:0]   gnt_idx;
    logic              grant_ok, violation, last;

    for (genvar i = 0; i < width; i++) begin : g_cnt
        request_pending_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (push[i]),
            .dec     (dec[i]),
            .nonzero (nonzero[i]),
            .is_one  (is_one[i]),
            .full    (pending_full[i])
        );
    end

    always_comb begin
        dec = '0;
        if (state_q == BURST) dec[ch_q] = 1'b1;
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < width; i++) begin
            if (grant[i]) gnt_idx = CH_W'(i);
        end
    end

    // A grant is only honoured if it is one-hot and lands on a channel we are requesting.
    assign grant_ok  = onehot(ONEHOT_MAX_W'(grant)) && ((grant & request) != '0);
    assign violation = (grant != '0) && ((state_q == BURST) || !grant_ok);
    // A same-cycle push to the last item keeps the burst alive.
    assign last      = (state_q == BURST) &&
                       ((beat_q == BC_W'(BURST_LEN - 1)) || (is_one[ch_q] && !push[ch_q]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    state_d = BURST;
                    ch_d    = gnt_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (last) state_d = IDLE;
                else      beat_d  = beat_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Error wins over a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (violation)    err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_comb begin
        request    = (state_q == IDLE) ? nonzero : '0;
        busy       = (state_q == BURST);
        beat_valid = (state_q == BURST);
        beat_ch    = (state_q == BURST) ? ch_q : '0;
        beat_last  = last;
    end

    assign grant_error = err_q;

endmodule
